// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared state encoding, op codes and saturation bounds for addsub_serial
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Two's-complement clamp value for a given width: most negative when neg=1, else most positive.
    function automatic logic [63:0] sat_bound(input int width, input logic neg);
        logic [63:0] max_pos;
        max_pos = (64'd1 << (width - 1)) - 64'd1;
        sat_bound = neg ? ~max_pos : max_pos;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// rtl/addsub_digit.sv - combinational DIGIT-bit ripple adder slice exposing the carry into its MSB
module addsub_digit
    import addsub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin
        logic c;
        c     = cin;
        c_msb = cin;
        s_d   = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s_d[i] = a_d[i] ^ b_d[i] ^ c;
            if (i == DIGIT - 1) c_msb = c;
            c = (a_d[i] & b_d[i]) | (c & (a_d[i] ^ b_d[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial signed add/subtract with carry/overflow/less-than; ADDSUB_SAT_EN enables result clamping
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             lessthan
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, b_sh_q, res_sh_q;
    logic [CW-1:0]      cnt_q;
    logic               carry_q, op_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_out_q, overflow_q, lessthan_q;

    logic               accept, last;
    logic [DIGIT-1:0]   s_d;
    logic               cout_d, c_msb_d;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]   res_sh_d, result_d;
    logic               ovf_d, lessthan_d;

    assign accept = start && (state_q != RUN);
    assign last   = (cnt_q == CW'(N - 1));

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d   (a_sh_q[DIGIT-1:0]),
        .b_d   (b_sh_q[DIGIT-1:0]),
        .cin   (carry_q),
        .s_d   (s_d),
        .cout  (cout_d),
        .c_msb (c_msb_d)
    );

    // Sum digits enter at the top and drift down, so after N steps digit 0 sits at bit 0.
    assign res_cat    = {s_d, res_sh_q};
    assign res_sh_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign ovf_d      = c_msb_d ^ cout_d;
    assign lessthan_d = (op_q == OP_SUB) && (res_sh_d[WIDTH-1] ^ ovf_d);

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_bound(WIDTH, 1'b0));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_bound(WIDTH, 1'b1));

    // A wrapped MSB of 1 on overflow means the true result was positive.
    always_comb begin
        result_d = res_sh_d;
        if (ovf_d) result_d = res_sh_d[WIDTH-1] ? SAT_MAX : SAT_MIN;
    end
`else
    assign result_d = res_sh_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            op_q        <= OP_ADD;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            lessthan_q  <= 1'b0;
        end else if (accept) begin
            a_sh_q  <= a;
            b_sh_q  <= (op == OP_SUB) ? ~b : b;
            carry_q <= op;
            op_q    <= op;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_sh_q   <= a_sh_q >> DIGIT;
            b_sh_q   <= b_sh_q >> DIGIT;
            res_sh_q <= res_sh_d;
            carry_q  <= cout_d;
            cnt_q    <= cnt_q + CW'(1);
            if (last) begin
                result_q    <= result_d;
                carry_out_q <= cout_d;
                overflow_q  <= ovf_d;
                lessthan_q  <= lessthan_d;
            end
        end
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign lessthan  = lessthan_q;

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - self-checking bench for addsub_serial (WIDTH=16, DIGIT=4); honours ADDSUB_SAT_EN
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, carry_out, overflow, lessthan;
    logic [15:0] result;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .lessthan  (lessthan)
    );

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        l;
    } exp_t;

    // Reference from plain integer arithmetic on the true signed values.
    function automatic exp_t model(input logic o, input logic [15:0] x, input logic [15:0] y);
        exp_t        m;
        int          sa = $signed(x);
        int          sb = $signed(y);
        int          t  = o ? (sa - sb) : (sa + sb);
        logic [16:0] u  = o ? ({1'b0, x} + {1'b0, ~y} + 17'd1) : ({1'b0, x} + {1'b0, y});
        m.c = u[16];
        m.v = (t > 32767) || (t < -32768);
        m.l = o && (sa < sb);
        m.r = t[15:0];
`ifdef ADDSUB_SAT_EN
        if (t > 32767)  m.r = 16'h7FFF;
        if (t < -32768) m.r = 16'h8000;
`endif
        return m;
    endfunction

    task automatic do_op(input logic o, input logic [15:0] x, input logic [15:0] y,
                         output int lat, output exp_t got);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        got.r = result; got.c = carry_out; got.v = overflow; got.l = lessthan;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, result, carry_out, overflow, lessthan} !== 21'd0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b result=%h c=%b v=%b l=%b want all zero",
                     busy, done, result, carry_out, overflow, lessthan);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        int   lat;
        exp_t got;
        do_op(1'b0, 16'd32767, -16'sd64, lat, got);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL add_latency got %0d want 4", lat); end
        checks++;
        if ({got.r, got.c, got.v} !== {16'h7FBF, 1'b1, 1'b0}) begin
            failures++; $display("FAIL add_max got r=%h c=%b v=%b want r=7fbf c=1 v=0", got.r, got.c, got.v);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== 16'h7FBF) begin
            failures++; $display("FAIL done_pulse_hold got done=%b r=%h want done=0 r=7fbf", done, result);
        end

        do_op(1'b1, 16'd32767, -16'sd64, lat, got);
        checks++;
`ifdef ADDSUB_SAT_EN
        if ({got.r, got.v, got.l} !== {16'h7FFF, 1'b1, 1'b0}) begin
            failures++; $display("FAIL sub_pos_ovf got r=%h v=%b l=%b want r=7fff v=1 l=0", got.r, got.v, got.l);
        end
`else
        if ({got.r, got.v, got.l} !== {16'h803F, 1'b1, 1'b0}) begin
            failures++; $display("FAIL sub_pos_ovf got r=%h v=%b l=%b want r=803f v=1 l=0", got.r, got.v, got.l);
        end
`endif

        do_op(1'b1, 16'h8000, 16'd1, lat, got);
        checks++;
`ifdef ADDSUB_SAT_EN
        if ({got.r, got.v, got.l} !== {16'h8000, 1'b1, 1'b1}) begin
            failures++; $display("FAIL sub_neg_ovf got r=%h v=%b l=%b want r=8000 v=1 l=1", got.r, got.v, got.l);
        end
`else
        if ({got.r, got.v, got.l} !== {16'h7FFF, 1'b1, 1'b1}) begin
            failures++; $display("FAIL sub_neg_ovf got r=%h v=%b l=%b want r=7fff v=1 l=1", got.r, got.v, got.l);
        end
`endif
    endtask

    task automatic test_random;
        int          lat;
        exp_t        got, exp;
        logic        o;
        logic [15:0] x, y;
        logic [15:0] corner [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
        for (int i = 0; i < 30; i++) begin
            o = 1'($urandom);
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
            exp = model(o, x, y);
            do_op(o, x, y, lat, got);
            checks++;
            if (got !== exp || lat !== 4) begin
                failures++;
                $display("FAIL random_%0d op=%b a=%h b=%h got r=%h c=%b v=%b l=%b lat=%0d want r=%h c=%b v=%b l=%b lat=4",
                         i, o, x, y, got.r, got.c, got.v, got.l, lat, exp.r, exp.c, exp.v, exp.l);
            end
        end
    endtask

    task automatic test_back_to_back;
        int   lat;
        exp_t got;
        do_op(1'b1, 16'd16, 16'd4, lat, got);
        checks++;
        if ({got.r, got.c, got.l} !== {16'd12, 1'b1, 1'b0}) begin
            failures++; $display("FAIL b2b_first got r=%h c=%b l=%b want r=000c c=1 l=0", got.r, got.c, got.l);
        end
        start = 1'b1; op = 1'b1; a = -16'sd1024; b = 16'd32767;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL b2b_spacing got %0d want 5", lat); end
        checks++;
`ifdef ADDSUB_SAT_EN
        if ({result, overflow, lessthan} !== {16'h8000, 1'b1, 1'b1}) begin
            failures++; $display("FAIL b2b_second got r=%h v=%b l=%b want r=8000 v=1 l=1", result, overflow, lessthan);
        end
`else
        if ({result, overflow, lessthan} !== {16'h7C01, 1'b1, 1'b1}) begin
            failures++; $display("FAIL b2b_second got r=%h v=%b l=%b want r=7c01 v=1 l=1", result, overflow, lessthan);
        end
`endif
    endtask

    task automatic test_start_hold;
        int   lat;
        int   extra;
        exp_t exp;
        logic [15:0] x = 16'($urandom), y = 16'($urandom);
        exp = model(1'b0, x, y);
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy got %b want 1", busy); end
        lat = 0;
        while (!done && lat < 20) begin
            a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (lat !== 4 || result !== exp.r || carry_out !== exp.c) begin
            failures++; $display("FAIL hold_operands got r=%h c=%b lat=%0d want r=%h c=%b lat=4", result, carry_out, lat, exp.r, exp.c);
        end
        extra = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (done) extra++;
        end
        checks++;
        if (extra !== 0 || busy !== 1'b0) begin
            failures++; $display("FAIL hold_single_done got extra=%0d busy=%b want 0 0", extra, busy);
        end
    endtask

    task automatic test_reset_midrun;
        int   lat;
        exp_t got;
        do_op(1'b0, 16'd1000, 16'd2000, lat, got);
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 16'd5; b = 16'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, result, carry_out, overflow, lessthan} !== 21'd0) begin
            failures++;
            $display("FAIL midrun_reset got busy=%b done=%b r=%h c=%b v=%b l=%b want all zero",
                     busy, done, result, carry_out, overflow, lessthan);
        end
        do_op(1'b0, 16'd256, -16'sd32, lat, got);
        checks++;
        if (got.r !== 16'd224 || lat !== 4) begin
            failures++; $display("FAIL after_reset got r=%h lat=%0d want r=00e0 lat=4", got.r, lat);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_start_hold;
        test_reset_midrun;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
